fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Control FSM for the pipelined fetch unit. Boots the PC from the start address and
//  inserts load-use stalls. Flushes IF/ID on taken branches and jumps. Drains the
//  pipeline and halts once end-of-program is fetched.
//  Drives the fetch stage's pcSelect/stall inputs; consumes its branchOut/endProgram.
// PARAMETERS
//  LOAD_STALL   1   bubble cycles inserted per load-use hazard (1..7)
//  DRAIN_CYCLES 3   cycles held in DRAIN after end_program so in-flight instrs retire (1..15)
//  CNT_W        16  width of performance counters (only with FETCH_PERF_EN)
// PORTS
//  clk           in   1      rising-edge clock
//  reset_n       in   1      asynchronous active-low reset
//  start         in   1      level; begin execution at startAddress
//  id_rs1        in   5      source reg 1 of instruction in ID
//  id_rs2        in   5      source reg 2 of instruction in ID
//  id_uses_rs2   in   1      ID instruction reads rs2
//  ex_rd         in   5      dest reg of instruction in EX
//  ex_mem_read   in   1      EX instruction is a load
//  branch_taken  in   1      branchOut from fetch (BEQZ/BNEZ resolved in ID)
//  jump          in   1      J/JR/JAL decoded in ID
//  end_program   in   1      endProgram from fetch
//  pc_select     out  1      1 = fetch uses startAddress
//  stall         out  1      freeze PC and IF/ID
//  if_id_flush   out  1      zero IF/ID register next edge
//  id_ex_bubble  out  1      inject NOP into ID/EX next edge
//  running       out  1      state in {RUN,STALL}
//  halted        out  1      state == HALT
//  stall_cnt     out  CNT_W  hazard bubble count (FETCH_PERF_EN only)
//  flush_cnt     out  CNT_W  redirect flush count (FETCH_PERF_EN only)
// BEHAVIOUR
//  States: IDLE, BOOT, RUN, STALL, DRAIN, HALT. Reset -> IDLE with pc_select=1, stall=1.
//   All other outputs 0; counters 0. reset_n low mid-run returns to IDLE immediately.
//  IDLE: pc_select=1, stall=1. start=1 -> BOOT.
//  BOOT: exactly 1 cycle. pc_select=1, stall=0, so the PC captures startAddress+4.
//   -> RUN.
//  RUN: pc_select=0. hazard = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | id_uses_rs2&ex_rd==id_rs2).
//   hazard: stall=1, id_ex_bubble=1 combinationally in the same cycle.
//    LOAD_STALL>1 -> STALL with bubble counter = LOAD_STALL-1.
//   else branch_taken|jump: if_id_flush=1 the same cycle; stay RUN (fetch redirects itself).
//   else end_program: stall=1 -> DRAIN, drain counter = DRAIN_CYCLES-1.
//   Priority: hazard > redirect > end_program. Redirect is ignored under hazard
//    (operands not valid yet).
//  STALL: stall=1, id_ex_bubble=1; decrement; at 0 -> RUN. Redirect inputs ignored.
//  DRAIN: stall=1.
//   branch_taken|jump -> if_id_flush=1, back to RUN (end_program was on a wrong path).
//   Counter 0 -> HALT.
//  HALT: stall=1, halted=1. start rising (0->1, registered) -> BOOT. Level-held start
//   does not re-boot.
//  Outputs are combinational from state + inputs. State and counters are registered.
//   No comb path from end_program to pc_select.
// CONFIGURATION
//  FETCH_PERF_EN defined: stall_cnt +1 per bubble cycle; flush_cnt +1 per if_id_flush cycle.
//   Both saturate at all-ones and clear on reset or BOOT.
//  Undefined: counter ports and logic absent.
// STRUCTURE
//  Package fetch_seq_pkg: state enum (3-bit), REG_ZERO=5'd0.
//  Sub-module load_use_detect: purely combinational hazard compare.
// TESTING
//  reset_n low, start=1 at cycle 3 -> BOOT at cycle 4 with pc_select=1, stall=0;
//   RUN at 5 with pc_select=0.
//  RUN, ex_mem_read=1, ex_rd=5, id_rs1=5 -> stall=id_ex_bubble=1 for exactly LOAD_STALL cycles.
//   ex_rd=0 gives no stall.
//  RUN, branch_taken=1 with hazard=1 -> stall only, flush=0.
//   Next cycle branch_taken=1, no hazard -> if_id_flush=1 for 1 cycle.
//  end_program=1 -> stall=1 for DRAIN_CYCLES, then halted=1. Jump pulse in DRAIN
//   -> flush, running=1.
//  HALT with start held high -> stays HALT. start 0->1 -> BOOT, counters cleared.
//  reset_n asserted in STALL -> outputs at reset values before next clk edge.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer and its hazard detector.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOOT,
        S_RUN,
        S_STALL,
        S_DRAIN,
        S_HALT
    } fetchState_t;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         SEQ_CNT_W = 4;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX load and the ID consumer.
module load_use_detect
    import fetch_seq_pkg::*;
(
    input  logic [4:0] idRs1,
    input  logic [4:0] idRs2,
    input  logic       idUsesRs2,
    input  logic [4:0] exRd,
    input  logic       exMemRead,
    output logic       hazard
);

    assign hazard = exMemRead && (exRd != REG_ZERO) &&
                    ((exRd == idRs1) || (idUsesRs2 && (exRd == idRs2)));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-unit control FSM: boot, load-use stalls, redirect flushes, drain and halt.
// Optional performance counters are built when FETCH_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, PC held on startAddress
// BOOT  | one cycle, PC captures startAddress+4
// RUN   | normal fetch, hazard/redirect/end_program handled here
// STALL | extra load-use bubble cycles
// DRAIN | letting in-flight instructions retire after end_program
// HALT  | stopped until a fresh start edge
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int LOAD_STALL   = 1,
    parameter int DRAIN_CYCLES = 3
`ifdef FETCH_PERF_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             end_program,
    output logic             pc_select,
    output logic             stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             running,
    output logic             halted
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [SEQ_CNT_W-1:0] STALL_LOAD = SEQ_CNT_W'(LOAD_STALL - 1);
    localparam logic [SEQ_CNT_W-1:0] DRAIN_LOAD = SEQ_CNT_W'(DRAIN_CYCLES - 1);

    fetchState_t            state, nextState;
    logic [SEQ_CNT_W-1:0]   seqCnt, nextCnt;
    logic                   startQ;
    logic                   hazard;
    logic                   redirect;

    load_use_detect uHazard (
        .idRs1     (id_rs1),
        .idRs2     (id_rs2),
        .idUsesRs2 (id_uses_rs2),
        .exRd      (ex_rd),
        .exMemRead (ex_mem_read),
        .hazard    (hazard)
    );

    assign redirect = branch_taken | jump;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            seqCnt <= '0;
            startQ <= 1'b0;
        end else begin
            state  <= nextState;
            seqCnt <= nextCnt;
            startQ <= start;
        end
    end

    always_comb begin
        nextState    = state;
        nextCnt      = seqCnt;
        pc_select    = 1'b0;
        stall        = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        running      = 1'b0;
        halted       = 1'b0;
        case (state)
            S_IDLE: begin
                pc_select = 1'b1;
                stall     = 1'b1;
                if (start) nextState = S_BOOT;
            end
            S_BOOT: begin
                pc_select = 1'b1;
                nextState = S_RUN;
            end
            S_RUN: begin
                running = 1'b1;
                // Redirect under a hazard is dropped: the branch operands are not valid yet.
                if (hazard) begin
                    stall        = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (LOAD_STALL > 1) begin
                        nextState = S_STALL;
                        nextCnt   = STALL_LOAD;
                    end
                end else if (redirect) begin
                    if_id_flush = 1'b1;
                end else if (end_program) begin
                    stall     = 1'b1;
                    nextState = S_DRAIN;
                    nextCnt   = DRAIN_LOAD;
                end
            end
            S_STALL: begin
                running      = 1'b1;
                stall        = 1'b1;
                id_ex_bubble = 1'b1;
                nextCnt      = seqCnt - SEQ_CNT_W'(1);
                if (seqCnt == SEQ_CNT_W'(1)) nextState = S_RUN;
            end
            S_DRAIN: begin
                stall = 1'b1;
                // A redirect here means end_program was fetched on a wrong path.
                if (redirect) begin
                    if_id_flush = 1'b1;
                    nextState   = S_RUN;
                end else if (seqCnt == '0) begin
                    nextState = S_HALT;
                end else begin
                    nextCnt = seqCnt - SEQ_CNT_W'(1);
                end
            end
            S_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
                if (start && !startQ) nextState = S_BOOT;
            end
            default: begin
                pc_select = 1'b1;
                stall     = 1'b1;
                nextState = S_IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == S_BOOT) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_ex_bubble && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
